// File: rtl/pcm_frame_buffer_if.sv
// Read-side ready/valid channel between the PCM frame buffer (master) and its consumer (slave).
interface pcm_frame_buffer_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] read_data_o;
   logic              read_valid_o;
   logic              read_ready_i;
   logic              buffer_ready_o;

   modport master (
      output read_data_o,
      output read_valid_o,
      output buffer_ready_o,
      input  read_ready_i
   );

   modport slave (
      input  read_data_o,
      input  read_valid_o,
      input  buffer_ready_o,
      output read_ready_i
   );
endinterface

// File: rtl/pcm_frame_buffer.sv
// Two-bank ping-pong capture of a PCM sample stream, each full bank streamed out over ready/valid.
// Optional macro PCM_FRAME_BUFFER_STATS_EN enables the saturating dropped-frame counter.
module pcm_frame_buffer #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 24
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [DATA_W-1:0]   sample_i,
   input  logic                sample_valid_i,
   pcm_frame_buffer_if.master  rd,
   output logic                overrun_o,
   output logic [15:0]         overrun_count_o
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ANNOUNCE = 2'd1,
      ST_STREAM   = 2'd2,
      ST_DONE     = 2'd3
   } rd_state_e;

   logic [DATA_W-1:0] mem_r [2*DEPTH];
   logic              wbank_r;
   logic [PTR_W-1:0]  wptr_r;
   logic              rbank_r;
   logic [PTR_W-1:0]  rptr_r;
   rd_state_e         state_r;
   logic [DATA_W-1:0] read_data_r;
   logic              read_valid_r;
   logic              buffer_ready_r;
   logic              overrun_r;

   rd_state_e         state_s;
   logic [PTR_W-1:0]  rptr_s;
   logic [PTR_W:0]    rd_addr_s;
   logic              rd_en_s;
   logic              complete_s;
   logic              reader_free_s;
   logic              handoff_s;
   logic              drop_s;
   logic              accept_s;

   // Bank completion and handoff/drop decision
   always_comb begin
      complete_s    = sample_valid_i && (wptr_r == PTR_LAST);
      reader_free_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
      handoff_s     = complete_s && reader_free_s;
      drop_s        = complete_s && !reader_free_s;
      accept_s      = (state_r == ST_STREAM) && rd.read_ready_i;
   end

   // Read FSM next state; RAM is addressed with the next pointer so data is ready without bubbles
   always_comb begin
      state_s = state_r;
      rptr_s  = rptr_r;
      rd_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (handoff_s) begin
               state_s = ST_ANNOUNCE;
               rptr_s  = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ANNOUNCE: begin
            state_s = ST_STREAM;
            rd_en_s = 1'b1;
         end
         ST_STREAM: begin
            if (accept_s) begin
               if (rptr_r == PTR_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  rptr_s  = rptr_r + PTR_W'(1);
                  rd_en_s = 1'b1;
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_DONE: begin
            if (handoff_s) begin
               state_s = ST_ANNOUNCE;
               rptr_s  = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      rd_addr_s = {rbank_r, rptr_s};
   end

   // Sample RAM write port; contents are not reset
   always_ff @(posedge clk_i) begin
      if (sample_valid_i) begin
         mem_r[{wbank_r, wptr_r}] <= sample_i;
      end
   end

   // Write pointer, write bank and sticky overrun flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wbank_r   <= 1'b0;
         wptr_r    <= '0;
         overrun_r <= 1'b0;
      end else begin
         if (sample_valid_i) begin
            if (complete_s) begin
               wptr_r <= '0;
               if (handoff_s) begin
                  wbank_r <= ~wbank_r;
               end
            end else begin
               wptr_r <= wptr_r + PTR_W'(1);
            end
         end
         if (drop_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   // Read FSM state, read pointer and registered read outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= ST_IDLE;
         rbank_r        <= 1'b0;
         rptr_r         <= '0;
         read_data_r    <= '0;
         read_valid_r   <= 1'b0;
         buffer_ready_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         rptr_r         <= rptr_s;
         read_valid_r   <= (state_s == ST_STREAM);
         buffer_ready_r <= (state_s == ST_ANNOUNCE);
         if (handoff_s) begin
            rbank_r <= wbank_r;
         end
         if (rd_en_s) begin
            read_data_r <= mem_r[rd_addr_s];
         end
      end
   end

`ifdef PCM_FRAME_BUFFER_STATS_EN
   logic [15:0] overrun_count_r;
   logic [31:0] frame_count_r;

   // Saturating dropped-frame counter and internal handed-off frame counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overrun_count_r <= 16'd0;
         frame_count_r   <= 32'd0;
      end else begin
         if (drop_s && (overrun_count_r != 16'hFFFF)) begin
            overrun_count_r <= overrun_count_r + 16'd1;
         end
         if (handoff_s) begin
            frame_count_r <= frame_count_r + 32'd1;
         end
      end
   end

   assign overrun_count_o = overrun_count_r;
`else
   assign overrun_count_o = 16'd0;
`endif

   assign rd.read_data_o    = read_data_r;
   assign rd.read_valid_o   = read_valid_r;
   assign rd.buffer_ready_o = buffer_ready_r;
   assign overrun_o         = overrun_r;
endmodule
